// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
// - state_e   : per-channel FSM encoding (3-bit)
// - cnt_width : width helper, clog2(max(a, b) + 1), sizes the hold counter
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CONF_PRESS = 3'd1,
        PRESSED    = 3'd2,
        REPEAT     = 3'd3,
        CONF_REL   = 3'd4
    } state_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-FF synchronizer, tick-qualified stability FSM,
// hold counter for long-press / auto-repeat, and registered outputs.
// Ports:
//   clk, rst      - system clock, async active-low reset
//   tick          - one-clk sample enable from the shared prescaler
//   i_btn         - raw asynchronous button input
//   i_repeat_en   - enables o_repeat pulses for this channel
//   o_level       - debounced level
//   o_press/o_release/o_long/o_repeat - one-clk event pulses
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);

    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = cnt_width(LONG_TICKS, REPEAT_TICKS);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_TICKS);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_TICKS);

    logic [1:0]    sync_q;
    logic          s;
    state_e        state_q, state_d;
    logic          ret_rep_q, ret_rep_d;   // state to resume after a release glitch
    logic [SW-1:0] stab_q, stab_d, stab_inc;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    assign s        = sync_q[1];
    assign stab_inc = stab_q + 1'b1;
    assign hold_inc = hold_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ret_rep_d = ret_rep_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (s) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = PRESSED;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            hold_d  = '0;
                        end else begin
                            state_d = CONF_PRESS;
                            stab_d  = SW'(1);
                        end
                    end
                end
                CONF_PRESS: begin
                    if (!s) begin
                        state_d = IDLE;
                        stab_d  = '0;
                    end else if (stab_inc == STAB_MAX) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hold_d  = '0;
                        stab_d  = '0;
                    end else begin
                        stab_d = stab_inc;
                    end
                end
                PRESSED, REPEAT: begin
                    if (!s) begin
                        ret_rep_d = (state_q == REPEAT);
                        if (STABLE_TICKS == 1) begin
                            state_d = IDLE;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                        end else begin
                            state_d = CONF_REL;
                            stab_d  = SW'(1);
                        end
                    end else if (state_q == PRESSED) begin
                        if (hold_inc == LONG_MAX) begin
                            state_d = REPEAT;
                            long_d  = 1'b1;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end else begin
                        // Period keeps running while repeat is disabled so
                        // enabling it mid-hold stays phase-aligned.
                        if (hold_inc == REP_MAX) begin
                            hold_d   = '0;
                            repeat_d = i_repeat_en;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                end
                CONF_REL: begin
                    // hold_q is intentionally untouched here: a short glitch
                    // resumes the hold count where it stopped.
                    if (s) begin
                        state_d = ret_rep_q ? REPEAT : PRESSED;
                        stab_d  = '0;
                    end else if (stab_inc == STAB_MAX) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        stab_d  = '0;
                    end else begin
                        stab_d = stab_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stab_d  = '0;
                    hold_d  = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            ret_rep_q <= 1'b0;
            stab_q    <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_btn};
            state_q   <= state_d;
            ret_rep_q <= ret_rep_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer with press/release/long/repeat events.
// A single prescaler produces a clock-enable tick shared by all channels;
// every flop runs on clk.
// Ports:
//   clk, rst     - system clock, async active-low reset
//   i_btn        - CH raw asynchronous button inputs
//   i_repeat_en  - CH per-channel auto-repeat enables
//   o_level      - CH debounced levels
//   o_press, o_release, o_long, o_repeat - CH one-clk event pulses
module button_debounce_multi
    import debounce_pkg::*;
#(
    parameter int CH           = 4,
    parameter int TICK_DIV     = 100,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] i_btn,
    input  logic [CH-1:0] i_repeat_en,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_press,
    output logic [CH-1:0] o_release,
    output logic [CH-1:0] o_long,
    output logic [CH-1:0] o_repeat
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic          tick;

    assign tick = (ps_q == PS_MAX);

    always_comb begin
        ps_d = tick ? '0 : ps_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ps_q <= '0;
        else      ps_q <= ps_d;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .i_btn      (i_btn[g]),
            .i_repeat_en(i_repeat_en[g]),
            .o_level    (o_level[g]),
            .o_press    (o_press[g]),
            .o_release  (o_release[g]),
            .o_long     (o_long[g]),
            .o_repeat   (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi (CH=2, TICK_DIV=10,
// STABLE_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=5).
module tb_button_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_btn, i_repeat_en;
    logic [1:0] o_level, o_press, o_release, o_long, o_repeat;

    button_debounce_multi #(
        .CH(2), .TICK_DIV(10), .STABLE_TICKS(4), .LONG_TICKS(20), .REPEAT_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .i_btn(i_btn), .i_repeat_en(i_repeat_en),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, excl_err = 0;
    int press_cnt[2], rel_cnt[2], long_cnt[2], rep_cnt[2];
    int press_cyc[2], rel_cyc[2], long_cyc[2], rep_first[2], rep_last[2];

    // Event recorder: counts cycles each pulse is high and stamps them.
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            if (o_press[ch])   begin press_cnt[ch]++; press_cyc[ch] = cyc; end
            if (o_release[ch]) begin rel_cnt[ch]++;   rel_cyc[ch]   = cyc; end
            if (o_long[ch])    begin long_cnt[ch]++;  long_cyc[ch]  = cyc; end
            if (o_repeat[ch]) begin
                if (rep_cnt[ch] == 0) rep_first[ch] = cyc;
                rep_cnt[ch]++;
                rep_last[ch] = cyc;
            end
            if ((o_long[ch] && o_repeat[ch]) || (o_press[ch] && o_release[ch])) excl_err++;
        end
    end

    task automatic clear_cnt();
        for (int ch = 0; ch < 2; ch++) begin
            press_cnt[ch] = 0; rel_cnt[ch] = 0; long_cnt[ch] = 0; rep_cnt[ch] = 0;
            press_cyc[ch] = 0; rel_cyc[ch] = 0; long_cyc[ch] = 0;
            rep_first[ch] = 0; rep_last[ch] = 0;
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int ch);
        for (int i = 0; i < 80 && press_cnt[ch] == 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; i_btn = 2'b00; i_repeat_en = 2'b00;
        clks(3);
        n_chk++; if ({o_level, o_press, o_release, o_long, o_repeat} !== 10'b0) $display("FAIL reset_outputs got=%b exp=0", {o_level, o_press, o_release, o_long, o_repeat}); else n_pass++;
        rst = 1'b1;
        clear_cnt();
        clks(30);
        n_chk++; if ({o_level, press_cnt[0], press_cnt[1]} !== 0) $display("FAIL idle_quiet got level=%b press=%0d/%0d exp 0", o_level, press_cnt[0], press_cnt[1]); else n_pass++;
    endtask

    task automatic test_clean_press();
        int t0;
        clear_cnt();
        i_btn[0] = 1'b1; t0 = cyc;
        clks(60);
        n_chk++; if (press_cnt[0] !== 1) $display("FAIL clean_press_cnt got=%0d exp=1", press_cnt[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b1) $display("FAIL clean_level got=%b exp=1", o_level[0]); else n_pass++;
        n_chk++; if (press_cyc[0] - t0 < 33 || press_cyc[0] - t0 > 42) $display("FAIL clean_latency got=%0d exp=33..42", press_cyc[0] - t0); else n_pass++;
        n_chk++; if ({press_cnt[1], rel_cnt[1], long_cnt[1]} !== 0) $display("FAIL clean_ch1_quiet got press=%0d rel=%0d", press_cnt[1], rel_cnt[1]); else n_pass++;
        n_chk++; if (o_level[1] !== 1'b0) $display("FAIL clean_ch1_level got=%b exp=0", o_level[1]); else n_pass++;
        i_btn[0] = 1'b0;
        clks(60);
        n_chk++; if (rel_cnt[0] !== 1) $display("FAIL clean_release_cnt got=%0d exp=1", rel_cnt[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b0) $display("FAIL clean_release_level got=%b exp=0", o_level[0]); else n_pass++;
    endtask

    task automatic test_bounce();
        int t0;
        clear_cnt();
        for (int i = 0; i < 20; i++) begin
            i_btn[0] = ~i_btn[0];
            clks(15);
        end
        n_chk++; if (press_cnt[0] !== 0) $display("FAIL bounce_no_press got=%0d exp=0", press_cnt[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b0) $display("FAIL bounce_level got=%b exp=0", o_level[0]); else n_pass++;
        i_btn[0] = 1'b1; t0 = cyc;
        clks(60);
        n_chk++; if (press_cnt[0] !== 1) $display("FAIL bounce_settle_press got=%0d exp=1", press_cnt[0]); else n_pass++;
        n_chk++; if (press_cyc[0] - t0 < 33 || press_cyc[0] - t0 > 42) $display("FAIL bounce_settle_latency got=%0d exp=33..42", press_cyc[0] - t0); else n_pass++;
        i_btn[0] = 1'b0;
        clks(60);
    endtask

    task automatic test_long_repeat();
        clear_cnt();
        i_repeat_en = 2'b01;
        i_btn[0] = 1'b1;
        wait_press(0);
        clks(330);
        n_chk++; if (long_cnt[0] !== 1) $display("FAIL long_cnt got=%0d exp=1", long_cnt[0]); else n_pass++;
        n_chk++; if (long_cyc[0] - press_cyc[0] !== 200) $display("FAIL long_delay got=%0d exp=200", long_cyc[0] - press_cyc[0]); else n_pass++;
        n_chk++; if (rep_cnt[0] !== 2) $display("FAIL repeat_cnt got=%0d exp=2", rep_cnt[0]); else n_pass++;
        n_chk++; if (rep_first[0] - long_cyc[0] !== 50) $display("FAIL repeat_first got=%0d exp=50", rep_first[0] - long_cyc[0]); else n_pass++;
        n_chk++; if (rep_last[0] - rep_first[0] !== 50) $display("FAIL repeat_period got=%0d exp=50", rep_last[0] - rep_first[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b1) $display("FAIL long_level got=%b exp=1", o_level[0]); else n_pass++;
        i_btn[0] = 1'b0;
        clks(60);
        clear_cnt();
        i_repeat_en = 2'b00;
        i_btn[0] = 1'b1;
        wait_press(0);
        clks(330);
        n_chk++; if (long_cnt[0] !== 1) $display("FAIL long_noen_cnt got=%0d exp=1", long_cnt[0]); else n_pass++;
        n_chk++; if (rep_cnt[0] !== 0) $display("FAIL repeat_disabled got=%0d exp=0", rep_cnt[0]); else n_pass++;
        i_btn[0] = 1'b0;
        clks(60);
    endtask

    task automatic test_release_glitch();
        clear_cnt();
        i_btn[0] = 1'b1;
        wait_press(0);
        clks(50);
        i_btn[0] = 1'b0;
        clks(20);
        i_btn[0] = 1'b1;
        clks(30);
        n_chk++; if (rel_cnt[0] !== 0) $display("FAIL glitch_no_release got=%0d exp=0", rel_cnt[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b1) $display("FAIL glitch_level got=%b exp=1", o_level[0]); else n_pass++;
        clks(200);
        // 2 low ticks plus the resume tick do not advance the hold count
        n_chk++; if (long_cnt[0] !== 1) $display("FAIL glitch_long_cnt got=%0d exp=1", long_cnt[0]); else n_pass++;
        n_chk++; if (long_cyc[0] - press_cyc[0] !== 230) $display("FAIL glitch_hold_resume got=%0d exp=230", long_cyc[0] - press_cyc[0]); else n_pass++;
        i_btn[0] = 1'b0;
        clks(60);
        n_chk++; if (rel_cnt[0] !== 1) $display("FAIL glitch_release_cnt got=%0d exp=1", rel_cnt[0]); else n_pass++;
        n_chk++; if (o_level[0] !== 1'b0) $display("FAIL glitch_release_level got=%b exp=0", o_level[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_confirm();
        int tr;
        clear_cnt();
        i_btn = 2'b10;
        wait_press(1);
        clks(2);
        i_btn = 2'b11;
        clks(22);
        n_chk++; if (o_level !== 2'b10) $display("FAIL rstmid_pre_level got=%b exp=10", o_level); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if ({o_level, o_press, o_release, o_long, o_repeat} !== 10'b0) $display("FAIL rstmid_async_clear got=%b exp=0", {o_level, o_press, o_release, o_long, o_repeat}); else n_pass++;
        clks(3);
        rst = 1'b1;
        clear_cnt();
        tr = cyc;
        clks(39);
        n_chk++; if (press_cnt[0] + press_cnt[1] !== 0) $display("FAIL rstmid_early_press got=%0d exp=0", press_cnt[0] + press_cnt[1]); else n_pass++;
        clks(1);
        n_chk++; if (press_cnt[0] !== 1 || press_cnt[1] !== 1) $display("FAIL rstmid_press_cnt got=%0d/%0d exp=1/1", press_cnt[0], press_cnt[1]); else n_pass++;
        n_chk++; if (press_cyc[0] - tr !== 40) $display("FAIL rstmid_press_time got=%0d exp=40", press_cyc[0] - tr); else n_pass++;
        n_chk++; if (o_level !== 2'b11) $display("FAIL rstmid_level got=%b exp=11", o_level); else n_pass++;
    endtask

    task automatic test_simultaneous();
        clear_cnt();
        i_btn = 2'b00;
        clks(60);
        n_chk++; if (rel_cnt[0] !== 1 || rel_cnt[1] !== 1) $display("FAIL sim_rel1_cnt got=%0d/%0d exp=1/1", rel_cnt[0], rel_cnt[1]); else n_pass++;
        n_chk++; if (rel_cyc[0] !== rel_cyc[1]) $display("FAIL sim_rel1_same got=%0d/%0d exp equal", rel_cyc[0], rel_cyc[1]); else n_pass++;
        clear_cnt();
        i_btn = 2'b11;
        clks(60);
        n_chk++; if (press_cnt[0] !== 1 || press_cnt[1] !== 1) $display("FAIL sim_press_cnt got=%0d/%0d exp=1/1", press_cnt[0], press_cnt[1]); else n_pass++;
        n_chk++; if (press_cyc[0] !== press_cyc[1]) $display("FAIL sim_press_same got=%0d/%0d exp equal", press_cyc[0], press_cyc[1]); else n_pass++;
        n_chk++; if (o_level !== 2'b11) $display("FAIL sim_press_level got=%b exp=11", o_level); else n_pass++;
        clear_cnt();
        i_btn = 2'b00;
        clks(60);
        n_chk++; if (rel_cnt[0] !== 1 || rel_cnt[1] !== 1) $display("FAIL sim_rel_cnt got=%0d/%0d exp=1/1", rel_cnt[0], rel_cnt[1]); else n_pass++;
        n_chk++; if (rel_cyc[0] !== rel_cyc[1]) $display("FAIL sim_rel_same got=%0d/%0d exp equal", rel_cyc[0], rel_cyc[1]); else n_pass++;
        n_chk++; if (o_level !== 2'b00) $display("FAIL sim_rel_level got=%b exp=00", o_level); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_reset_mid_confirm();
        test_simultaneous();
        n_chk++; if (excl_err !== 0) $display("FAIL exclusivity got=%0d exp=0", excl_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
